pixel_row_collector: RTL and testbench
======================================

PIXEL_ROW_COLLECTOR -- requirements
Module: pixel_row_collector

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, bit width of one sample.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  producer presents a sample on in_data.
REQ-005 SHALL have port in_data  input  DATAWIDTH  serial sample stream, index 0 first.
REQ-006 SHALL have port in_ready  output  1  collector accepts a sample this cycle.
REQ-007 SHALL have ports out_0 .. out_15  output  DATAWIDTH each  parallel 16-sample row, out_k = k-th accepted sample of the row.
REQ-008 SHALL have port out_valid  output  1  out_0..out_15 hold a complete row.
REQ-009 SHALL have port out_ready  input  1  consumer takes the row this cycle.

Function
REQ-010 SHALL contain a collect buffer (16 x DATAWIDTH), a 4-bit write index cnt, a collect-full flag cfull, and an output buffer (16 x DATAWIDTH) driving out_0..out_15.
REQ-011 SHALL drive in_ready = !cfull, decoded from registered state only (no combinational path from out_ready or in_valid).
REQ-012 Input accept = in_valid && in_ready; on accept SHALL write in_data to collect slot cnt and increment cnt modulo 16.
REQ-013 On accept with cnt == 15 SHALL set cfull and wrap cnt to 0.
REQ-014 Transfer = cfull && (!out_valid || out_ready); on transfer SHALL copy all 16 collect slots to the output buffer, set out_valid, clear cfull, in one edge.
REQ-015 When out_valid && out_ready and no transfer in that cycle, SHALL clear out_valid; output buffer contents SHALL be retained, unchanged.
REQ-016 Simultaneous consume and transfer SHALL leave out_valid = 1 with the new row loaded (back-to-back rows, no bubble on output).
REQ-017 Output buffer SHALL change only on transfer; out_0..out_15 SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-018 Latency: last sample (slot 15) accepted at edge E, cfull high after E, out_valid high after E+1 if output free; i.e. two edges.
REQ-019 While cfull = 1 no sample SHALL be accepted; in_data ignored regardless of in_valid.
REQ-020 Sustained throughput with out_ready held high SHALL be 16 samples per 17 cycles (one in_ready = 0 cycle per row).
REQ-021 in_valid low cycles SHALL not advance cnt; partial rows SHALL persist indefinitely.
REQ-022 out_valid SHALL never assert for a partial row.

Reset
REQ-023 On reset = 1 at a rising edge SHALL set cnt = 0, cfull = 0, out_valid = 0, all out_k = 0, all collect slots = 0.
REQ-024 Reset SHALL override accept, transfer and consume in the same cycle; partially collected or pending rows SHALL be discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-026 Reset, then 16 consecutive samples 0x00..0x0F with out_ready = 1 -> out_valid rises 2 edges after sample 0x0F accepted, out_k = k, in_ready = 0 exactly one cycle.
REQ-027 Stream 32 samples 0x10..0x2F with out_ready = 0 -> row 1 (0x10..0x1F) held on outputs, second row fills collector, in_ready = 0 after 0x2F; raise out_ready one cycle -> out_k = 0x20+k, out_valid stays 1.
REQ-028 Random in_valid gaps (50 %) over 64 samples, out_ready = 1 -> four rows, each out_k equals k-th sample of its row, no sample lost or duplicated.
REQ-029 Assert reset after 9 samples of a row and while a row is pending on outputs -> next cycle out_valid = 0, all out_k = 0, in_ready = 1; next 16 samples form a fresh row starting at out_0.
REQ-030 Hold out_valid = 1, out_ready = 0 for 20 cycles with in_valid = 1 -> out_k unchanged, exactly 16 further samples accepted, then in_ready = 0 until out_ready pulses.

Source files
------------

// File: rtl/pixel_row_collector.sv
// rtl/pixel_row_collector.sv - serial-to-parallel collector assembling 16-sample rows
// Double-buffered: one row fills the collector while the previous row is held on the outputs.
module pixel_row_collector #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_0,
    output logic [DATAWIDTH-1:0] out_1,
    output logic [DATAWIDTH-1:0] out_2,
    output logic [DATAWIDTH-1:0] out_3,
    output logic [DATAWIDTH-1:0] out_4,
    output logic [DATAWIDTH-1:0] out_5,
    output logic [DATAWIDTH-1:0] out_6,
    output logic [DATAWIDTH-1:0] out_7,
    output logic [DATAWIDTH-1:0] out_8,
    output logic [DATAWIDTH-1:0] out_9,
    output logic [DATAWIDTH-1:0] out_10,
    output logic [DATAWIDTH-1:0] out_11,
    output logic [DATAWIDTH-1:0] out_12,
    output logic [DATAWIDTH-1:0] out_13,
    output logic [DATAWIDTH-1:0] out_14,
    output logic [DATAWIDTH-1:0] out_15,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [DATAWIDTH-1:0] r_coll [16];
    logic [DATAWIDTH-1:0] r_obuf [16];
    logic [3:0]           r_cnt;
    logic                 r_cfull;
    logic                 r_out_valid;

    logic w_accept;
    logic w_transfer;
    logic w_consume;

    // in_ready comes straight from a flop so the producer never sees a path from out_ready.
    assign in_ready   = !r_cfull;
    assign w_accept   = in_valid && !r_cfull;
    assign w_transfer = r_cfull && (!r_out_valid || out_ready);
    assign w_consume  = r_out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                r_coll[k] <= '0;
                r_obuf[k] <= '0;
            end
            r_cnt       <= 4'd0;
            r_cfull     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // accept needs !cfull and transfer needs cfull, so they never collide on r_cfull
            if (w_accept) begin
                r_coll[r_cnt] <= in_data;
                r_cnt         <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_cfull <= 1'b1;
                end
            end
            if (w_transfer) begin
                for (int k = 0; k < 16; k++) begin
                    r_obuf[k] <= r_coll[k];
                end
                r_out_valid <= 1'b1;
                r_cfull     <= 1'b0;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_0  = r_obuf[0];
    assign out_1  = r_obuf[1];
    assign out_2  = r_obuf[2];
    assign out_3  = r_obuf[3];
    assign out_4  = r_obuf[4];
    assign out_5  = r_obuf[5];
    assign out_6  = r_obuf[6];
    assign out_7  = r_obuf[7];
    assign out_8  = r_obuf[8];
    assign out_9  = r_obuf[9];
    assign out_10 = r_obuf[10];
    assign out_11 = r_obuf[11];
    assign out_12 = r_obuf[12];
    assign out_13 = r_obuf[13];
    assign out_14 = r_obuf[14];
    assign out_15 = r_obuf[15];

endmodule

// File: tb/tb_pixel_row_collector.sv
// tb/tb_pixel_row_collector.sv - scoreboard bench for pixel_row_collector
module tb_pixel_row_collector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] w_out [16];
    logic [127:0] w_row;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_ordy = 1'b0;

    always #5 clock = ~clock;

    pixel_row_collector #(.DATAWIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_0(w_out[0]), .out_1(w_out[1]), .out_2(w_out[2]), .out_3(w_out[3]),
        .out_4(w_out[4]), .out_5(w_out[5]), .out_6(w_out[6]), .out_7(w_out[7]),
        .out_8(w_out[8]), .out_9(w_out[9]), .out_10(w_out[10]), .out_11(w_out[11]),
        .out_12(w_out[12]), .out_13(w_out[13]), .out_14(w_out[14]), .out_15(w_out[15]),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always_comb begin
        w_row = '0;
        for (int k = 0; k < 16; k++) w_row[k*8 +: 8] = w_out[k];
    end

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples accumulate in a queue; each complete row is queued for the output side.
    logic [7:0]   coll_q [$];
    logic [127:0] exp_rows [$];
    bit           m_full = 1'b0;
    bit           m_ov = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            coll_q.delete();
            exp_rows.delete();
            m_full = 1'b0;
            m_ov   = 1'b0;
        end else begin
            bit tr;
            bit cons;
            chk(in_ready == !m_full, "in_ready", {127'd0, in_ready}, {127'd0, !m_full});
            chk(out_valid == m_ov, "out_valid", {127'd0, out_valid}, {127'd0, m_ov});
            tr   = m_full && (!m_ov || out_ready);
            cons = m_ov && out_ready;
            if (in_valid && !m_full) begin
                coll_q.push_back(in_data);
                if (coll_q.size() == 16) begin
                    logic [127:0] r;
                    r = '0;
                    for (int k = 0; k < 16; k++) r[k*8 +: 8] = coll_q[k];
                    exp_rows.push_back(r);
                    coll_q.delete();
                    m_full = 1'b1;
                end
            end
            if (tr) begin
                m_full = 1'b0;
                m_ov   = 1'b1;
            end else if (cons) begin
                m_ov = 1'b0;
            end
        end
    end

    // Output monitor: a displayed row must match the queue head; an idle output keeps the last row.
    logic [127:0] last_row = '0;

    always @(negedge clock) begin
        if (reset) begin
            last_row = '0;
        end else if (out_valid) begin
            if (exp_rows.size() == 0) begin
                chk(1'b0, "unexpected_row", w_row, '0);
            end else begin
                chk(w_row == exp_rows[0], "row_data", w_row, exp_rows[0]);
                if (out_ready) last_row = exp_rows.pop_front();
            end
        end else begin
            chk(w_row == last_row, "row_retained", w_row, last_row);
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] d, input int gap_pct);
        bit ok;
        int t;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            t++;
        end
        if (!ok) chk(1'b0, "send_timeout", {120'd0, d}, '0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int lows;
        int acc;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk(in_ready == 1'b1, "ready_after_reset", {127'd0, in_ready}, 128'd1);
        chk(out_valid == 1'b0, "valid_after_reset", {127'd0, out_valid}, 128'd0);
        chk(w_row == '0, "zero_after_reset", w_row, '0);
        @(posedge clock);
        #1;

        // Back-to-back row with consumer ready: one in_ready-low cycle per row
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (!in_ready) lows++;
            if (i == 1) chk(out_valid == 1'b1, "latency_two_edges", {127'd0, out_valid}, 128'd1);
        end
        chk(lows == 1, "ready_low_cycles", 128'(lows), 128'd1);
        @(posedge clock);
        #1;

        // Consumer stalled: row 1 held, row 2 fills collector, then simultaneous consume+transfer
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(8'(8'h10 + i), 0);
        idle(2);
        @(negedge clock);
        chk(in_ready == 1'b0, "ready_low_when_full", {127'd0, in_ready}, 128'd0);
        chk(w_out[15] == 8'h1F, "row1_held", {120'd0, w_out[15]}, 128'h1F);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk(out_valid == 1'b1, "no_bubble", {127'd0, out_valid}, 128'd1);
        chk(w_out[0] == 8'h20 && w_out[15] == 8'h2F, "row2_loaded", w_row, 128'h20);

        // Hold the output for 20 cycles with in_valid high: exactly one row more is absorbed
        @(posedge clock);
        #1;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(8'h40 + i);
            @(negedge clock);
            if (in_ready) acc++;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        chk(acc == 16, "hold_accept_count", 128'(acc), 128'd16);
        @(negedge clock);
        chk(in_ready == 1'b0, "hold_ready_low", {127'd0, in_ready}, 128'd0);
        chk(w_out[0] == 8'h20, "hold_stable", {120'd0, w_out[0]}, 128'h20);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        idle(6);

        // Random gaps, consumer always ready
        for (int i = 0; i < 64; i++) send(8'($urandom), 50);
        idle(4);

        // Random gaps with a randomly stalling consumer
        rand_ordy = 1'b1;
        for (int i = 0; i < 64; i++) send(8'($urandom), 30);
        rand_ordy = 1'b0;
        #2;
        out_ready = 1'b1;
        idle(6);

        // Reset mid-row while a row is pending on the outputs
        out_ready = 1'b0;
        for (int i = 0; i < 25; i++) send(8'($urandom), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk(out_valid == 1'b0, "reset_valid", {127'd0, out_valid}, 128'd0);
        chk(in_ready == 1'b1, "reset_ready", {127'd0, in_ready}, 128'd1);
        chk(w_row == '0, "reset_outputs", w_row, '0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 0);
        idle(3);
        @(negedge clock);
        chk(w_out[0] == 8'hA0 && w_out[15] == 8'hAF, "fresh_row", w_row, 128'hA0);
        chk(exp_rows.size() == 0, "rows_drained", 128'(exp_rows.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
